// File: rtl/mux_pkg.sv
// Shared definitions for the mux datapath leaf and its environment.
//   MUX_WIDTH  : default data word width
//   mux_word_t : data word type at the default width
//   SEL_A/B    : select-line encoding (0 picks a, 1 picks b)
package mux_pkg;

  localparam int MUX_WIDTH = 4;

  typedef logic [MUX_WIDTH-1:0] mux_word_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_comb.sv
// Combinational 2:1 selector, WIDTH bits, purely bitwise.
// Ports:
//   a   : word chosen when sel == SEL_A
//   b   : word chosen when sel == SEL_B
//   sel : select line
//   y   : selected word (combinational)
module mux2_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // One selector per bit; no bit interacts with any other.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i] = (sel == SEL_B) ? b[i] : a[i];
  end

endmodule

// File: rtl/mux_modport.sv
// Registered 2:1 word multiplexer. The selected word is captured on the
// rising edge of clk and presented on y one cycle later; y comes only from
// the output register.
// Ports:
//   clk : clock, rising-edge sampling
//   rst : asynchronous active-low reset, forces y to RST_VAL at once
//   a   : word selected when sel = 0
//   b   : word selected when sel = 1
//   sel : select line
//   y   : registered result
module mux_modport
  import mux_pkg::*;
#(
  parameter int               WIDTH   = MUX_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] y_next;

  mux2_comb #(.WIDTH(WIDTH)) u_mux (
    .a   (a),
    .b   (b),
    .sel (sel),
    .y   (y_next)
  );

  // Reset release is synchronised upstream, so no local synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) y <= RST_VAL;
    else      y <= y_next;
  end

endmodule

// File: tb/tb_mux_modport.sv
// Self-checking bench for mux_modport: directed reset/select/boundary cases,
// an asynchronous mid-stream reset, then 1000 random cycles. Expected words
// travel through a queue: each driven cycle pushes the word the reference
// selector picks, and each check pops the word due on y.
module tb_mux_modport;
  import mux_pkg::*;

  localparam int        W    = MUX_WIDTH;
  localparam mux_word_t RVAL = '0;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  mux_word_t a   = '0;
  mux_word_t b   = '0;
  logic      sel = 1'b0;
  mux_word_t y;

  int checks = 0;
  int errors = 0;

  mux_word_t exp_q[$];
  string     tag_q[$];

  mux_modport #(.WIDTH(W), .RST_VAL(RVAL)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sel (sel),
    .y   (y)
  );

  always #5 clk = ~clk;

  // Reference selector written as a mask blend.
  function automatic mux_word_t ref_sel(mux_word_t av, mux_word_t bv, logic sv);
    mux_word_t m;
    m = sv ? '1 : '0;
    return (av & ~m) | (bv & m);
  endfunction

  task automatic chk(input string tag, input mux_word_t got, input mux_word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: y=%h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Queue the word the currently held inputs will produce at the next edge.
  task automatic prime(input string tag);
    exp_q.push_back(ref_sel(a, b, sel));
    tag_q.push_back(tag);
  endtask

  // New inputs launched after the edge with skews (sel/b at +1, a at +2),
  // then y is checked mid-cycle against the word sampled at that edge.
  task automatic step(input mux_word_t av, input mux_word_t bv, input logic sv,
                      input string tag);
    @(posedge clk);
    #1 sel = sv; b = bv;
    #1 a = av;
    @(negedge clk);
    chk(tag_q.pop_front(), y, exp_q.pop_front());
    exp_q.push_back(ref_sel(av, bv, sv));
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      chk(tag_q.pop_front(), y, exp_q.pop_front());
    end
  endtask

  // Assertions bound to the DUT behaviour.
  a_rst_val : assert property (@(posedge clk) !rst |-> y == RVAL);
  a_data    : assert property (@(posedge clk) disable iff (!rst)
                               $past(rst) |-> y == $past(sel ? b : a));
  a_sel_x   : assert property (@(posedge clk) rst |-> !$isunknown(sel));

  initial begin
    // Reset held across 3 edges with a=A, b=5, sel=1.
    a = 4'hA; b = 4'h5; sel = 1'b1;
    #1 rst = 1'b0;
    #1 chk("rst_t0", y, RVAL);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_hold%0d", i), y, RVAL);
    end
    rst = 1'b1;                        // released between edges
    prime("rst_release");              // expect 5 after first edge

    step(4'h3, 4'hC, 1'b0, "sel_a");
    step(4'h3, 4'hC, 1'b1, "tog_b0");
    step(4'h3, 4'hC, 1'b0, "tog_a0");
    step(4'h3, 4'hC, 1'b1, "tog_b1");
    step(4'h3, 4'hC, 1'b0, "tog_a1");
    step(4'hF, 4'h0, 1'b0, "bnd_a_all1");
    step(4'hF, 4'h0, 1'b1, "bnd_b_all0");
    step(4'h9, 4'h6, 1'b0, "pre_rst_9");
    drain();
    chk("pre_rst_hold", y, 4'h9);

    // Mid-stream asynchronous reset between edges.
    #2 rst = 1'b0;
    #1 chk("async_drop", y, RVAL);
    a = 4'h7; b = 4'hE; sel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("async_hold", y, RVAL);
    rst = 1'b1;
    prime("resume");                   // expect E after first edge

    for (int i = 0; i < 1000; i++)
      step(mux_word_t'($urandom), mux_word_t'($urandom), 1'($urandom),
           $sformatf("rnd%0d", i));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
